// File: rtl/ef_sha256_pkg.sv
// Shared types and constants for the SHA-256 message sequencer.
package ef_sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_LEN,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } state_t;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;
  localparam int WORDS    = 16;

  localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
  localparam int          LEN_HI_IDX = 14;
  localparam int          LEN_LO_IDX = 15;

endpackage

// File: rtl/ef_sha256_pad_word.sv
// Masks the final message word to its valid bytes and appends the 0x80 marker.
module ef_sha256_pad_word
  import ef_sha256_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_bytes,
  output logic [31:0] o_word,
  output logic [2:0]  o_nbytes
);

  always_comb begin
    o_nbytes = (i_bytes > 3'd4) ? 3'd4 : i_bytes;
    o_word   = PAD_WORD;
    case (o_nbytes)
      3'd1:    o_word = {i_data[31:24], 8'h80, 16'h0000};
      3'd2:    o_word = {i_data[31:16], 8'h80, 8'h00};
      3'd3:    o_word = {i_data[31:8], 8'h80};
      3'd4:    o_word = i_data;
      default: o_word = PAD_WORD;
    endcase
  end

endmodule

// File: rtl/ef_sha256_seq.sv
// Assembles a byte-counted word stream into padded 512-bit blocks and
// sequences init/next commands into the SHA-256 compression core.
module ef_sha256_seq
  import ef_sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [31:0]         s_data,
  input  logic                s_last,
  input  logic [2:0]          s_bytes,
  output logic                core_init,
  output logic                core_next,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic                core_ready,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic [DIGEST_W-1:0] digest,
  output logic                done,
  output logic                busy
);

  state_t              r_state;
  logic [31:0]         r_block [WORDS];
  logic [4:0]          r_wcnt;
  logic [LEN_W-1:0]    r_len;
  logic                r_first;
  logic                r_xtra;
  logic                r_final;
  logic                r_pend;
  logic                r_wait1;
  logic                r_init;
  logic                r_next;
  logic                r_done;
  logic [DIGEST_W-1:0] r_digest;

  logic [31:0] w_pad_word;
  logic [2:0]  w_nbytes;
  logic [4:0]  w_pad_idx;
  logic [3:0]  w_wr_idx;
  logic [3:0]  w_nxt_idx;
  logic [63:0] w_len64;

  ef_sha256_pad_word u_pad_word (
    .i_data   (s_data),
    .i_bytes  (s_bytes),
    .o_word   (w_pad_word),
    .o_nbytes (w_nbytes)
  );

  // Index of the word that carries the 0x80 marker; 16 means it spills into the next block.
  assign w_pad_idx = r_wcnt + ((w_nbytes == 3'd4) ? 5'd1 : 5'd0);
  assign w_wr_idx  = r_wcnt[3:0];
  assign w_nxt_idx = w_wr_idx + 4'd1;
  assign w_len64   = 64'(r_len);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state  <= ST_IDLE;
      r_wcnt   <= '0;
      r_len    <= '0;
      r_first  <= 1'b0;
      r_xtra   <= 1'b0;
      r_final  <= 1'b0;
      r_pend   <= 1'b0;
      r_wait1  <= 1'b0;
      r_init   <= 1'b0;
      r_next   <= 1'b0;
      r_done   <= 1'b0;
      r_digest <= '0;
      for (int i = 0; i < WORDS; i++) r_block[i] <= '0;
    end else begin
      r_init <= 1'b0;
      r_next <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_wcnt  <= '0;
            r_len   <= '0;
            r_first <= 1'b1;
            r_xtra  <= 1'b0;
            r_final <= 1'b0;
            r_pend  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            r_block[w_wr_idx] <= s_last ? w_pad_word : s_data;
            if (!s_last) begin
              r_len <= r_len + LEN_W'(32);
              if (r_wcnt == 5'd15) r_state <= ST_ISSUE;
              else                 r_wcnt  <= r_wcnt + 5'd1;
            end else begin
              r_len <= r_len + LEN_W'({w_nbytes, 3'b000});
              if (w_pad_idx == 5'd16) begin
                r_pend  <= 1'b1;
                r_xtra  <= 1'b1;
                r_state <= ST_ISSUE;
              end else begin
                if (w_nbytes == 3'd4) r_block[w_nxt_idx] <= PAD_WORD;
                r_wcnt  <= w_pad_idx + 5'd1;
                r_xtra  <= (w_pad_idx > 5'd13);
                r_state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          if (!r_wcnt[4]) r_block[w_wr_idx] <= '0;
          if (r_xtra) begin
            if (r_wcnt >= 5'd15) r_state <= ST_ISSUE;
            else                 r_wcnt  <= r_wcnt + 5'd1;
          end else begin
            if (r_wcnt >= 5'd13) r_state <= ST_LEN;
            else                 r_wcnt  <= r_wcnt + 5'd1;
          end
        end
        ST_LEN: begin
          r_block[LEN_HI_IDX] <= w_len64[63:32];
          r_block[LEN_LO_IDX] <= w_len64[31:0];
          r_final             <= 1'b1;
          r_state             <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_init  <= r_first;
          r_next  <= !r_first;
          r_first <= 1'b0;
          r_wait1 <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // core_ready may still be high in the cycle the command is visible to the core
          r_wait1 <= 1'b0;
          if (!r_wait1 && core_ready) begin
            if (r_final) begin
              r_digest <= core_digest;
              r_done   <= 1'b1;
              r_state  <= ST_FIN;
            end else if (r_xtra) begin
              r_block[0] <= r_pend ? PAD_WORD : 32'h0;
              r_wcnt     <= 5'd1;
              r_xtra     <= 1'b0;
              r_pend     <= 1'b0;
              r_state    <= ST_PAD;
            end else begin
              r_wcnt  <= '0;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_blk
      assign core_block[BLOCK_W-1-32*gi -: 32] = r_block[gi];
    end
  endgenerate

  assign s_ready   = (r_state == ST_LOAD);
  assign busy      = (r_state != ST_IDLE);
  assign core_init = r_init;
  assign core_next = r_next;
  assign done      = r_done;
  assign digest    = r_digest;

endmodule

// File: tb/tb_ef_sha256_seq.sv
// Randomized bench: FIPS 180-4 padding reference plus a behavioural SHA-256 core model.
module tb_ef_sha256_seq;

  logic         CLK = 1'b0;
  logic         RESETn;
  logic         start;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [2:0]   s_bytes;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_ready;
  logic [255:0] core_digest;
  logic [255:0] digest;
  logic         done;
  logic         busy;

  always #5 CLK = ~CLK;

  ef_sha256_seq #(.LEN_W(64)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_digest(core_digest),
    .digest(digest), .done(done), .busy(busy)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           done_cnt = 0;
  int           blk_seen = 0;
  int           bp_err   = 0;
  bit           aborted  = 1'b0;
  logic [7:0]   msg [$];
  logic [511:0] exp_blk [$];
  logic [511:0] seen_blk [$];
  logic [255:0] exp_digest;
  logic [255:0] core_h;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
             + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Byte-level FIPS 180-4 padding of the current message into expected blocks.
  task automatic build_expected();
    logic [7:0]   q [$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    logic [255:0] h;
    q = msg;
    bitlen = 64'(msg.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int k = 7; k >= 0; k--) q.push_back(bitlen[8*k +: 8]);
    exp_blk.delete();
    h = IV;
    for (int b = 0; b < q.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = q[64*b+j];
      exp_blk.push_back(blk);
      h = sha_compress(h, blk);
    end
    exp_digest = h;
  endtask

  task automatic set_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic set_fill(input int n, input logic [7:0] v);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(v);
  endtask

  task automatic set_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Core model: ready drops right after a command, returns after a random latency.
  initial begin
    logic [511:0] blk;
    logic         was_init;
    core_ready  = 1'b1;
    core_digest = '0;
    core_h      = '0;
    forever begin
      @(negedge CLK);
      if (core_init || core_next) begin
        blk      = core_block;
        was_init = core_init;
        core_ready = 1'b0;
        check("cmd_kind", {core_init, core_next}, (blk_seen == 0) ? 2'b10 : 2'b01);
        if (blk_seen < exp_blk.size()) check("block", blk, exp_blk[blk_seen]);
        else                           check("extra_block", blk_seen, exp_blk.size());
        blk_seen++;
        seen_blk.push_back(blk);
        core_h = sha_compress(was_init ? IV : core_h, blk);
        repeat ($urandom_range(1, 5)) @(negedge CLK);
        if (!aborted) check("blk_stable", core_block, blk);
        core_digest = core_h;
        core_ready  = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (done) done_cnt++;
  end

  task automatic chk_reset_state();
    check("rst_s_ready", s_ready, 0);
    check("rst_core_init", core_init, 0);
    check("rst_core_next", core_next, 0);
    check("rst_core_block", core_block, 0);
    check("rst_digest", digest, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic run_msg(input bit hold, input bit abort);
    int n, nw, cnt, t, dc0;
    logic [31:0] wd;
    build_expected();
    n   = msg.size();
    nw  = (n == 0) ? 1 : (n + 3) / 4;
    blk_seen = 0;
    seen_blk.delete();
    bp_err = 0;
    dc0 = done_cnt;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    for (int i = 0; i < nw; i++) begin
      if (i > 0) @(negedge CLK);
      if (!hold && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(negedge CLK);
      end
      cnt = (n - 4 * i > 4) ? 4 : n - 4 * i;
      wd  = $urandom();
      for (int j = 0; j < cnt; j++) wd[31-8*j -: 8] = msg[4*i+j];
      s_valid = 1'b1;
      s_data  = wd;
      s_last  = (i == nw - 1);
      if (i != nw - 1)  s_bytes = 3'($urandom);
      else if (cnt == 4) s_bytes = 3'(4 + $urandom_range(0, 3));
      else               s_bytes = 3'(cnt);
      t = 0;
      while (!s_ready && t < 300) begin @(negedge CLK); t++; end
      if (t >= 300) check("accept_timeout", s_ready, 1);
      @(posedge CLK);
    end
    @(negedge CLK);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("sready_drop", s_ready, 0);
    if (abort) begin
      t = 0;
      while (!core_init && t < 300) begin @(negedge CLK); t++; end
      check("abort_init_seen", core_init, 1);
      aborted = 1'b1;
      RESETn  = 1'b0;
      @(posedge CLK); #1;
      chk_reset_state();
      @(negedge CLK); RESETn = 1'b1;
      t = 0;
      while (!core_ready && t < 50) begin @(negedge CLK); t++; end
      aborted = 1'b0;
      $display("msg len=%0d aborted during WAIT", n);
      return;
    end
    if (hold) begin
      s_valid = 1'b1;
      s_data  = 32'hdead_beef;
      start   = 1'b1;
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge CLK);
      t++;
      if (hold && s_ready) bp_err++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    check("done_seen", done, 1);
    check("digest", digest, exp_digest);
    repeat (3) @(negedge CLK);
    check("done_once", done_cnt - dc0, 1);
    check("block_count", blk_seen, exp_blk.size());
    check("idle_after", busy, 0);
    if (hold) check("backpressure", bp_err, 0);
    $display("msg len=%0d hold=%0d blocks=%0d digest=%0h", n, hold, blk_seen, digest);
  endtask

  initial begin
    int lens [14] = '{52, 53, 54, 55, 56, 57, 59, 60, 61, 63, 64, 65, 119, 120};
    RESETn = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0;
    repeat (3) @(negedge CLK);
    chk_reset_state();
    RESETn = 1'b1;

    set_str("abc");
    run_msg(1'b0, 1'b0);
    check("kat_abc", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    msg.delete();
    run_msg(1'b0, 1'b0);
    check("kat_empty", digest, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    if (seen_blk.size() > 0) check("empty_w0", seen_blk[0][511:480], 32'h8000_0000);

    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_msg(1'b0, 1'b0);
    check("kat_56", digest, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

    set_fill(55, 8'h61);
    run_msg(1'b0, 1'b0);
    if (seen_blk.size() > 0) begin
      check("a55_w13_tail", seen_blk[0][71:64], 8'h80);
      check("a55_w15", seen_blk[0][31:0], 32'h1B8);
    end

    set_fill(64, 8'h61);
    run_msg(1'b0, 1'b0);
    if (seen_blk.size() > 1) begin
      check("a64_b1_w0", seen_blk[1][511:480], 32'h8000_0000);
      check("a64_b1_w15", seen_blk[1][31:0], 32'h200);
    end

    set_rand(100);
    run_msg(1'b1, 1'b0);

    for (int i = 0; i < 14; i++) begin
      set_rand(lens[i]);
      run_msg(1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      set_rand($urandom_range(0, 150));
      run_msg(1'($urandom_range(0, 1)), 1'b0);
    end

    set_str("abc");
    run_msg(1'b0, 1'b1);
    set_str("abc");
    run_msg(1'b0, 1'b0);
    check("kat_abc_after_reset", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ef_sha256_seq.md
# ef_sha256_seq

Message sequencer for the EF_SHA256 compression core. It accepts a byte-counted 32-bit word stream and assembles 512-bit blocks, applying FIPS 180-4 padding and the 64-bit length field. It issues init/next commands to the core, waits on its ready flag, and presents the final 256-bit digest. It sits between the bus wrappers' data FIFO and the core.

## Interface
- LEN_W, 64, message bit-length counter width; the length field is zero-extended to 64 bits.
- CLK  in  1  clock, rising edge
- RESETn  in  1  synchronous active-low reset
- start  in  1  in IDLE: begin a new message, clear length; ignored elsewhere
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- s_data  in  32  big-endian; byte0 = s_data[31:24]
- s_last  in  1  final word of the message
- s_bytes  in  3  valid bytes in the last word, 0..4; values >4 are treated as 4; ignored when s_last=0
- core_init  out  1  one-cycle pulse for the first block
- core_next  out  1  one-cycle pulse for subsequent blocks
- core_block  out  512  block; word0 = [511:480]; stable from the pulse until core_ready returns
- core_ready  in  1  core idle; must drop within 1 cycle of init/next
- core_digest  in  256  valid when core_ready=1 after the final block
- digest  out  256  captured result, held until the next start
- done  out  1  one-cycle pulse when digest is updated
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, PAD, LEN, ISSUE, WAIT, FIN.
- IDLE: s_ready=0. start → LOAD with wcnt=0, len=0, first=1, xtra=0.
- LOAD: s_ready=1. Each accepted word is written to block word[wcnt] and wcnt increments.
  - Non-last word: len += 32. If wcnt was 15 → ISSUE.
  - Last word: len += 8·s_bytes. The word is masked to s_bytes bytes. For s_bytes<4, byte s_bytes = 0x80 and the rest are 0. For s_bytes=4, word[wcnt+1] is set to 0x80000000; if wcnt was 15, xtra=1 and that pad word goes to word0 of the next block.
  - After the last word: if the pad word index ≤13 → PAD (zero-fill to word 13), otherwise zero-fill to word 15 and set xtra=1.
- PAD: writes one zero word per cycle. It reaches word 13 → LEN, or word 15 with xtra → ISSUE.
- LEN: words 14/15 = len[63:32]/len[31:0], written in one cycle; final=1 → ISSUE.
- ISSUE: pulse core_init if first, else core_next; clear first → WAIT.
- WAIT: ignore core_ready in the first WAIT cycle, then wait for core_ready=1. Next state:
  - final → FIN.
  - xtra → PAD. The new block is all zero (or word0=0x80000000 if the pad word is pending), then LEN.
  - otherwise → LOAD with wcnt=0.
- FIN: digest ← core_digest, done=1 → IDLE.
- len wraps modulo 2^LEN_W. No overflow is flagged.
- Empty message (s_last with s_bytes=0 as the first word): one block, word0=0x80000000, len=0.

## Timing
- Reset values: s_ready=0, core_init=0, core_next=0, core_block=0, digest=0, done=0, busy=0, state=IDLE.
- Reset mid-operation aborts to IDLE in the same edge. The core is not re-initialised until the next start.
- One word per cycle in LOAD. s_ready drops in the cycle after the 16th word or the last word.
- Command pulse lasts exactly 1 cycle. The block is not modified in ISSUE or WAIT.
- done is asserted 1 cycle after core_ready is seen high in WAIT for the final block.
- start while busy: ignored. s_valid outside LOAD: held, not consumed.

## Structure
- Package ef_sha256_pkg holds:
  - the state enum;
  - BLOCK_W=512, DIGEST_W=256, WORDS=16;
  - PAD_WORD=32'h8000_0000, LEN_HI_IDX=14, LEN_LO_IDX=15.
- Sub-module ef_sha256_pad_word: combinational mask of the last word plus 0x80 insertion, from (s_data, s_bytes).

## Test plan
- "abc" (one word, s_bytes=3) → single core_init; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message → block word0=80000000, words 14/15=0; digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdef…nopq" → init then next (extra block); digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 55 bytes of 0x61 → exactly one block; word13 ends 0x80, word15=0x1B8. 64 bytes → two blocks; second block word0=80000000, word15=0x200.
- Backpressure: s_valid held high through WAIT → s_ready=0, no word lost; done fires once.
- RESETn low during WAIT → all outputs reach reset values next cycle. A following start with "abc" yields the correct digest.
